// File: rtl/one_to_four_demux_pkg.sv
// Shared constants for the registered 1:4 demux router.
package one_to_four_demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    localparam logic [SEL_W-1:0] CH_OUT1 = 2'd0;
    localparam logic [SEL_W-1:0] CH_OUT2 = 2'd1;
    localparam logic [SEL_W-1:0] CH_OUT3 = 2'd2;
    localparam logic [SEL_W-1:0] CH_OUT4 = 2'd3;

endpackage

// File: rtl/demux_channel_slot.sv
// Single-entry channel holding register with load/drain handshake.
module demux_channel_slot #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    // A load on the draining edge replaces the consumed word, so full stays set.
    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
            data <= '0;
        end else if (load) begin
            full <= 1'b1;
            data <= load_data;
        end else if (full && ready) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/one_to_four_demux_router.sv
// Registered 1:4 valid/ready router steered by {s1,s0}.
// Define ONE_TO_FOUR_DEMUX_RR_EN to add rr_mode round-robin steering.
module one_to_four_demux_router
    import one_to_four_demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    s0,
    input  logic                    s1,
`ifdef ONE_TO_FOUR_DEMUX_RR_EN
    input  logic                    rr_mode,
`endif
    output logic                    in_ready,
    output logic [NUM_CH-1:0]       out_valid,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    input  logic [NUM_CH-1:0]       out_ready
);

    logic [SEL_W-1:0]  dest;
    logic [NUM_CH-1:0] full;
    logic              accept;

`ifdef ONE_TO_FOUR_DEMUX_RR_EN
    logic [SEL_W-1:0] rr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (rr_mode && accept) begin
            rr_ptr <= rr_ptr + 2'd1;
        end
    end

    assign dest = rr_mode ? rr_ptr : {s1, s0};
`else
    assign dest = {s1, s0};
`endif

    assign in_ready  = !full[dest] || out_ready[dest];
    assign accept    = in_valid && in_ready;
    assign out_valid = full;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        demux_channel_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .load     (accept && (dest == SEL_W'(k))),
            .load_data(in_data),
            .ready    (out_ready[k]),
            .full     (full[k]),
            .data     (out_data[k*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_one_to_four_demux_router.sv
// Directed self-checking bench for one_to_four_demux_router (WIDTH=8).
module tb_one_to_four_demux_router;
    import one_to_four_demux_pkg::*;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          s0, s1;
    logic          rr_mode;
    logic          in_ready;
    logic [3:0]    out_valid;
    logic [4*W-1:0] out_data;
    logic [3:0]    out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    one_to_four_demux_router #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .s0       (s0),
        .s1       (s1),
`ifdef ONE_TO_FOUR_DEMUX_RR_EN
        .rr_mode  (rr_mode),
`endif
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sel(input logic [1:0] d);
        {s1, s0} = d;
    endtask

    function automatic logic [7:0] ch(input int k);
        return out_data[k*W +: W];
    endfunction

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        s0        = 1'b0;
        s1        = 1'b0;
        rr_mode   = 1'b0;
        out_ready = 4'b0000;

        // reset held two cycles with in_valid high
        step();
        step();
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data", out_data, 32'h0);
        reset    = 1'b0;
        in_valid = 1'b0;
        step();
        check("rst_noacc", 32'(out_valid), 32'h0);

        // routing, all consumers ready
        out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hA0 + 8'(i);
            sel(2'(i));
            step();
            check($sformatf("route_v%0d", i), 32'(out_valid), 32'(1 << i));
            check($sformatf("route_d%0d", i), 32'(ch(i)), 32'hA0 + i);
        end
        in_valid = 1'b0;
        step();
        check("route_drained", 32'(out_valid), 32'h0);
        check("route_kept", out_data, 32'hA3A2A1A0);

        // back-pressure on channel 2
        out_ready = 4'b1011;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        sel(CH_OUT3);
        #1;
        check("bp_rdy_empty", 32'(in_ready), 32'h1);
        step();
        check("bp_v1", 32'(out_valid), 32'h4);
        check("bp_d1", 32'(ch(2)), 32'h55);
        in_data = 8'h66;
        #1;
        check("bp_rdy_full", 32'(in_ready), 32'h0);
        step();
        check("bp_hold_v", 32'(out_valid), 32'h4);
        check("bp_hold_d", 32'(ch(2)), 32'h55);
        out_ready = 4'b1111;
        #1;
        check("bp_rdy_drain", 32'(in_ready), 32'h1);
        step();
        check("bp_swap_v", 32'(out_valid), 32'h4);
        check("bp_swap_d", 32'(ch(2)), 32'h66);
        in_valid = 1'b0;
        step();
        check("bp_empty", 32'(out_valid), 32'h0);

        // independence: ch3 stalled, write ch1
        out_ready = 4'b0111;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        sel(CH_OUT4);
        step();
        check("ind_v3", 32'(out_valid), 32'h8);
        #1;
        check("ind_rdy3", 32'(in_ready), 32'h0);
        in_data = 8'h88;
        sel(CH_OUT2);
        #1;
        check("ind_rdy1", 32'(in_ready), 32'h1);
        step();
        check("ind_v", 32'(out_valid), 32'hA);
        check("ind_d1", 32'(ch(1)), 32'h88);
        check("ind_d3", 32'(ch(3)), 32'h77);

        // fill all channels, then reset mid-operation
        out_ready = 4'b0000;
        in_data   = 8'h99;
        sel(CH_OUT1);
        step();
        in_data = 8'hAA;
        sel(CH_OUT3);
        step();
        in_valid = 1'b0;
        step();
        check("full_v", 32'(out_valid), 32'hF);
        check("full_d", out_data, 32'h77AA8899);
        for (int d = 0; d < 4; d++) begin
            sel(2'(d));
            #1;
            check($sformatf("full_rdy%0d", d), 32'(in_ready), 32'h0);
        end
        in_valid = 1'b1;
        in_data  = 8'h11;
        reset    = 1'b1;
        step();
        check("mid_rst_v", 32'(out_valid), 32'h0);
        check("mid_rst_d", out_data, 32'h0);
        reset    = 1'b0;
        in_valid = 1'b0;

`ifdef ONE_TO_FOUR_DEMUX_RR_EN
        // round-robin: 5 words land on 0,1,2,3,0
        out_ready = 4'b1111;
        rr_mode   = 1'b1;
        sel(2'd0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hB0 + 8'(i);
            step();
            check($sformatf("rr_v%0d", i), 32'(out_valid), 32'(1 << (i % 4)));
            check($sformatf("rr_d%0d", i), 32'(ch(i % 4)), 32'hB0 + i);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        // stall channel 1: pointer reaches 1 again and must hold
        out_ready = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hC0 + 8'(i);
            step();
        end
        check("rr_st_d1", 32'(ch(1)), 32'hC1);
        #1;
        check("rr_st_rdy", 32'(in_ready), 32'h0);
        in_data = 8'hCF;
        step();
        check("rr_st_rdy2", 32'(in_ready), 32'h0);
        check("rr_st_hold", 32'(ch(1)), 32'hC1);
        out_ready = 4'b1111;
        in_data   = 8'hD0;
        #1;
        check("rr_go_rdy", 32'(in_ready), 32'h1);
        step();
        check("rr_go_d1", 32'(ch(1)), 32'hD0);
        in_valid = 1'b0;
        rr_mode  = 1'b0;
        step();
`endif

        // first accept after reset still routes normally
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        sel(CH_OUT4);
        step();
        check("post_v", 32'(out_valid), 32'h8);
        check("post_d", 32'(ch(3)), 32'h3C);
        in_valid = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
